// File: rtl/axi_apb_pkg.sv
// Shared types and constants for the AXI4-Lite write path feeding axi_to_apb_bridge.
//   AXI_ADDR_W / AXI_DATA_W : default address and data widths
//   RESP_*                  : AXI B-channel response encodings
//   axi_wr_cmd_t            : one buffered write command {addr, data} at default widths
package axi_apb_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_DATA_W-1:0] data;
  } axi_wr_cmd_t;

endpackage

// File: rtl/axi_write_cmd_master_if.sv
// AXI4-Lite write-side channels (AW, W, B) between a write master and its slave.
//   master modport : drives awaddr/awvalid, wdata/wvalid, bready
//   slave modport  : drives awready, wready, bvalid/bresp
interface axi_write_cmd_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic              wvalid;
  logic              wready;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready,
    output awready, wready, bvalid, bresp
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read port.
//   push/wdata : write when not full (push while full is ignored)
//   pop/rdata  : rdata shows the head; pop advances when not empty
//   full/empty/count : occupancy derived from read/write pointers
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [Width-1:0]       wdata,
  input  logic                   pop,
  output logic [Width-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] PtrOne = (PtrW + 1)'(1);

  logic [PtrW:0]      wr_ptr_q, rd_ptr_q;
  logic [Width-1:0]   mem_q [Depth];
  logic               do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                 (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign rdata = mem_q[rd_ptr_q[PtrW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  // Storage needs no reset: entries are only visible between pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/axi_write_cmd_master.sv
// Command-driven AXI4-Lite write master.
//   clk, rst_n            : clock, asynchronous active-low reset
//   cmd_valid/ready/addr/data : write-command push port into the command FIFO
//   axi (master)          : AW/W issue with independent handshakes, B collection
//   err_clr               : clears err_sticky (a same-cycle error wins)
//   busy                  : FIFO non-empty, entry in flight, or writes outstanding
//   outstanding           : writes handshaken on AW/W awaiting B
//   wr_done_cnt           : wrapping count of B handshakes
//   err_sticky            : a non-OKAY bresp has been seen
module axi_write_cmd_master
  import axi_apb_pkg::*;
#(
  parameter int unsigned ADDR_W          = AXI_ADDR_W,
  parameter int unsigned DATA_W          = AXI_DATA_W,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic [ADDR_W-1:0]                    cmd_addr,
  input  logic [DATA_W-1:0]                    cmd_data,
  axi_write_cmd_master_if.master               axi,
  input  logic                                 err_clr,
  output logic                                 busy,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic [15:0]                          wr_done_cnt,
  output logic                                 err_sticky
);

  localparam int unsigned CmdW = ADDR_W + DATA_W;
  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OutW-1:0] OutOne = OutW'(1);
  localparam logic [OutW-1:0] OutMax = OutW'(MAX_OUTSTANDING);

  logic                        fifo_full, fifo_empty;
  logic [CmdW-1:0]             head;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  logic push, launch, aw_hs, w_hs, complete, b_hs;

  logic              inflight_q, aw_sent_q, w_sent_q;
  logic              awvalid_q, wvalid_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [OutW-1:0]   outstanding_q, outstanding_d;
  logic [15:0]       done_cnt_q;
  logic              err_q;

  assign cmd_ready = ~fifo_full;
  assign push      = cmd_valid & cmd_ready;

  sync_fifo #(
    .Width (CmdW),
    .Depth (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({cmd_addr, cmd_data}),
    .pop   (complete),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    aw_hs    = awvalid_q & axi.awready;
    w_hs     = wvalid_q & axi.wready;
    // The entry completes on whichever edge finishes the later of the two channels.
    complete = inflight_q & (aw_sent_q | aw_hs) & (w_sent_q | w_hs);
    // Throttle only gates launch; an entry already in flight always finishes.
    launch   = ~fifo_empty & ~inflight_q & (outstanding_q < OutMax);
    b_hs     = axi.bvalid & axi.bready;

    outstanding_d = outstanding_q;
    case ({complete, b_hs})
      2'b10:   outstanding_d = outstanding_q + OutOne;
      2'b01:   outstanding_d = outstanding_q - OutOne;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Issue state: launch and complete are exclusive since launch needs !inflight_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      aw_sent_q  <= 1'b0;
      w_sent_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
    end else if (launch) begin
      inflight_q <= 1'b1;
      aw_sent_q  <= 1'b0;
      w_sent_q   <= 1'b0;
      awvalid_q  <= 1'b1;
      wvalid_q   <= 1'b1;
      awaddr_q   <= head[CmdW-1:DATA_W];
      wdata_q    <= head[DATA_W-1:0];
    end else if (complete) begin
      inflight_q <= 1'b0;
      aw_sent_q  <= 1'b0;
      w_sent_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
    end else begin
      if (aw_hs) begin
        awvalid_q <= 1'b0;
        aw_sent_q <= 1'b1;
      end
      if (w_hs) begin
        wvalid_q <= 1'b0;
        w_sent_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
      done_cnt_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      if (b_hs) done_cnt_q <= done_cnt_q + 16'd1;
      if (b_hs && (axi.bresp != RESP_OKAY)) err_q <= 1'b1;
      else if (err_clr)                     err_q <= 1'b0;
    end
  end

  assign axi.awaddr  = awaddr_q;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = (outstanding_q != '0);

  assign busy        = (fifo_count != '0) | inflight_q | (outstanding_q != '0);
  assign outstanding = outstanding_q;
  assign wr_done_cnt = done_cnt_q;
  assign err_sticky  = err_q;

endmodule
